// File: rtl/dmem_bus_bridge.sv
// Data-memory bus bridge between the MEM stage and a req/ack system bus.
// Stores are posted through a single-entry buffer; loads block via pause until ack or timeout.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Zz_addr,
  input  logic [31:0] Zz_dout,
  input  logic [3:0]  Zz_wr_en,
  input  logic        rd_en,
  output logic [31:0] zZ_din,
  output logic        pause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RDONE
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        wr;
  logic        rd;
  logic        expired;
  logic        addr_lsb_unused;

  assign wr              = |Zz_wr_en;
  assign rd              = rd_en & ~wr;
  assign expired         = (cnt == LAST_CNT);
  assign addr_lsb_unused = ^Zz_addr[1:0];

  // In WR any new access waits for the buffer to drain, then IDLE accepts it.
  always_comb begin
    pause = 1'b0;
    unique case (state)
      IDLE:    pause = rd;
      WR:      pause = wr | rd_en;
      RD:      pause = 1'b1;
      RDONE:   pause = 1'b0;
      default: pause = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      zZ_din      <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      bus_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr) begin
            bus_addr  <= {Zz_addr[31:2], 2'b00};
            bus_wdata <= Zz_dout;
            bus_be    <= Zz_wr_en;
            bus_we    <= 1'b1;
            bus_req   <= 1'b1;
            cnt       <= '0;
            state     <= WR;
          end else if (rd) begin
            bus_addr  <= {Zz_addr[31:2], 2'b00};
            bus_wdata <= Zz_dout;
            bus_be    <= '1;
            bus_we    <= 1'b0;
            bus_req   <= 1'b1;
            cnt       <= '0;
            state     <= RD;
          end
        end
        WR: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end else if (expired) begin
            bus_req     <= 1'b0;
            bus_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RD: begin
          // An ack on the final count cycle still wins over the abort.
          if (bus_ack) begin
            zZ_din  <= bus_rdata;
            bus_req <= 1'b0;
            state   <= RDONE;
          end else if (expired) begin
            zZ_din      <= '0;
            bus_req     <= 1'b0;
            bus_timeout <= 1'b1;
            state       <= RDONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RDONE: begin
          // Request inputs still show the retiring load here; do not re-issue it.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: expected bus transactions and load data are queued
// as stimulus is driven and checked when the bridge puts them on the bus or retires a load.
module tb_dmem_bus_bridge;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          ack_on;
    logic [31:0] rdata;
  } txn_t;

  logic        clk;
  logic        rst;
  logic [31:0] Zz_addr;
  logic [31:0] Zz_dout;
  logic [3:0]  Zz_wr_en;
  logic        rd_en;
  logic [31:0] zZ_din;
  logic        pause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_timeout;

  int vectors = 0;
  int miscompares = 0;

  txn_t        sb[$];
  logic [31:0] rd_exp[$];
  txn_t        cur;
  logic        have_cur = 1'b0;
  logic        prev_req = 1'b0;
  int          req_len = 0;
  int          last_req_len = 0;

  dmem_bus_bridge #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Zz_addr    (Zz_addr),
    .Zz_dout    (Zz_dout),
    .Zz_wr_en   (Zz_wr_en),
    .rd_en      (rd_en),
    .zZ_din     (zZ_din),
    .pause      (pause),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_timeout(bus_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: pops the expected transaction when bus_req rises, checks the bus
  // fields every request cycle and acks on the transaction's programmed cycle.
  always @(negedge clk) begin
    if (bus_req) begin
      if (!prev_req) begin
        req_len = 0;
        if (sb.size() == 0) begin
          have_cur = 1'b0;
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got bus_req=1 addr=%h, want no request", bus_addr);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
        end
      end
      req_len++;
      if (have_cur) begin
        vectors++;
        if ({bus_addr, bus_be, bus_we} !== {cur.addr, cur.be, cur.we}) begin
          miscompares++;
          $display("FAIL bus_fields: got addr=%h be=%b we=%b, want addr=%h be=%b we=%b",
                   bus_addr, bus_be, bus_we, cur.addr, cur.be, cur.we);
        end
        if (cur.we) begin
          vectors++;
          if (bus_wdata !== cur.wdata) begin
            miscompares++;
            $display("FAIL bus_wdata: got %h, want %h", bus_wdata, cur.wdata);
          end
        end
        bus_ack   = (cur.ack_on == req_len);
        bus_rdata = cur.rdata;
      end else begin
        bus_ack = 1'b0;
      end
    end else begin
      if (prev_req) last_req_len = req_len;
      bus_ack = 1'b0;
    end
    prev_req = bus_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1);
  end

  task automatic push_txn(input logic [31:0] addr, input logic [3:0] be, input logic we,
                          input logic [31:0] wdata, input int ack_on, input logic [31:0] rdata);
    txn_t t;
    t.addr = addr; t.be = be; t.we = we; t.wdata = wdata; t.ack_on = ack_on; t.rdata = rdata;
    sb.push_back(t);
  endtask

  // Presents one core access, holds it while pause=1, returns stall cycles and state at retire.
  task automatic core_access(input logic is_wr, input logic [31:0] addr, input logic [31:0] dout,
                             input logic [3:0] wr_en, output int pcnt, output logic [31:0] din,
                             output logic req_at_retire, output logic ok);
    Zz_addr  = addr;
    Zz_dout  = dout;
    Zz_wr_en = is_wr ? wr_en : 4'b0000;
    rd_en    = ~is_wr;
    pcnt = 0;
    ok = 1'b0;
    din = '0;
    req_at_retire = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (!pause) begin
        ok = 1'b1;
        din = zZ_din;
        req_at_retire = bus_req;
        break;
      end
      pcnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd_en    = 1'b0;
    Zz_wr_en = 4'b0000;
  endtask

  task automatic wait_bus_idle(output int pause_seen, output logic ok);
    pause_seen = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pause) pause_seen++;
      if (sb.size() == 0 && !bus_req) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    Zz_addr = '0; Zz_dout = '0; Zz_wr_en = '0; rd_en = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    #12;
    vectors++;
    if ({zZ_din, bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_timeout, pause} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got din=%h req=%b we=%b addr=%h be=%b wdata=%h to=%b pause=%b, want all 0",
               zZ_din, bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_timeout, pause);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus_req, pause} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: got req=%b pause=%b, want 0 0", bus_req, pause);
    end
  endtask

  task automatic test_posted_store;
    int pcnt, pseen;
    logic [31:0] din;
    logic r, ok;
    push_txn(32'h0000_1004, 4'b0011, 1'b1, 32'hCCDD_CCDD, 3, 32'h0);
    core_access(1'b1, 32'h0000_1006, 32'hCCDD_CCDD, 4'b0011, pcnt, din, r, ok);
    vectors++;
    if (!ok || pcnt != 0) begin
      miscompares++;
      $display("FAIL store_stall: got ok=%b pause_cycles=%0d, want 1 0", ok, pcnt);
    end
    wait_bus_idle(pseen, ok);
    vectors++;
    if (!ok || pseen != 0 || last_req_len != 3) begin
      miscompares++;
      $display("FAIL store_req_len: got ok=%b pause=%0d req_cycles=%0d, want 1 0 3", ok, pseen, last_req_len);
    end
  endtask

  task automatic test_load_wait;
    int pcnt, pseen;
    logic [31:0] din;
    logic r, ok;
    push_txn(32'h0000_2000, 4'b1111, 1'b0, 32'h0, 3, 32'h1234_5678);
    rd_exp.push_back(32'h1234_5678);
    core_access(1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0000, pcnt, din, r, ok);
    vectors++;
    if (!ok || pcnt != 4) begin
      miscompares++;
      $display("FAIL load_stall: got ok=%b pause_cycles=%0d, want 1 4", ok, pcnt);
    end
    vectors++;
    if (din !== rd_exp.pop_front() || r !== 1'b0) begin
      miscompares++;
      $display("FAIL load_data: got din=%h req=%b, want 12345678 0", din, r);
    end
    wait_bus_idle(pseen, ok);
    vectors++;
    if (!ok || last_req_len != 3) begin
      miscompares++;
      $display("FAIL load_req_len: got ok=%b req_cycles=%0d, want 1 3", ok, last_req_len);
    end
  endtask

  task automatic test_back_to_back;
    int pcnt, pseen;
    logic [31:0] din;
    logic r, ok;
    push_txn(32'h0000_0040, 4'b1111, 1'b1, 32'h1122_3344, 2, 32'h0);
    push_txn(32'h0000_0040, 4'b1111, 1'b0, 32'h0, 1, 32'h1122_3344);
    rd_exp.push_back(32'h1122_3344);
    core_access(1'b1, 32'h0000_0040, 32'h1122_3344, 4'b1111, pcnt, din, r, ok);
    vectors++;
    if (!ok || pcnt != 0) begin
      miscompares++;
      $display("FAIL b2b_store_stall: got ok=%b pause_cycles=%0d, want 1 0", ok, pcnt);
    end
    core_access(1'b0, 32'h0000_0040, 32'h0, 4'b0000, pcnt, din, r, ok);
    vectors++;
    if (!ok || pcnt != 4) begin
      miscompares++;
      $display("FAIL b2b_load_stall: got ok=%b pause_cycles=%0d, want 1 4", ok, pcnt);
    end
    vectors++;
    if (din !== rd_exp.pop_front()) begin
      miscompares++;
      $display("FAIL b2b_load_data: got %h, want 11223344", din);
    end
    wait_bus_idle(pseen, ok);
    vectors++;
    if (!ok || last_req_len != 1) begin
      miscompares++;
      $display("FAIL b2b_req_len: got ok=%b req_cycles=%0d, want 1 1", ok, last_req_len);
    end
  endtask

  task automatic test_boundary_ack;
    int pcnt, pseen;
    logic [31:0] din;
    logic r, ok;
    push_txn(32'h0000_0300, 4'b1111, 1'b0, 32'h0, 4, 32'hA5A5_A5A5);
    rd_exp.push_back(32'hA5A5_A5A5);
    core_access(1'b0, 32'h0000_0301, 32'h0, 4'b0000, pcnt, din, r, ok);
    vectors++;
    if (!ok || pcnt != 5 || din !== rd_exp.pop_front()) begin
      miscompares++;
      $display("FAIL boundary_load: got ok=%b pause_cycles=%0d din=%h, want 1 5 a5a5a5a5", ok, pcnt, din);
    end
    wait_bus_idle(pseen, ok);
    vectors++;
    if (!ok || bus_timeout !== 1'b0 || last_req_len != 4) begin
      miscompares++;
      $display("FAIL boundary_timeout: got ok=%b timeout=%b req_cycles=%0d, want 1 0 4", ok, bus_timeout, last_req_len);
    end
  endtask

  task automatic test_load_timeout;
    int pcnt, pseen;
    logic [31:0] din;
    logic r, ok;
    push_txn(32'h0000_0400, 4'b1111, 1'b0, 32'h0, 0, 32'hFFFF_FFFF);
    rd_exp.push_back(32'h0);
    core_access(1'b0, 32'h0000_0400, 32'h0, 4'b0000, pcnt, din, r, ok);
    vectors++;
    if (!ok || pcnt != 5 || din !== rd_exp.pop_front()) begin
      miscompares++;
      $display("FAIL timeout_load: got ok=%b pause_cycles=%0d din=%h, want 1 5 00000000", ok, pcnt, din);
    end
    wait_bus_idle(pseen, ok);
    vectors++;
    if (!ok || bus_timeout !== 1'b1 || last_req_len != 4) begin
      miscompares++;
      $display("FAIL timeout_flag: got ok=%b timeout=%b req_cycles=%0d, want 1 1 4", ok, bus_timeout, last_req_len);
    end
    push_txn(32'h0000_0404, 4'b1111, 1'b0, 32'h0, 1, 32'h0BAD_F00D);
    rd_exp.push_back(32'h0BAD_F00D);
    core_access(1'b0, 32'h0000_0406, 32'h0, 4'b0000, pcnt, din, r, ok);
    vectors++;
    if (!ok || pcnt != 2 || din !== rd_exp.pop_front() || bus_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky_load: got ok=%b pause_cycles=%0d din=%h timeout=%b, want 1 2 0badf00d 1",
               ok, pcnt, din, bus_timeout);
    end
    push_txn(32'h0000_0408, 4'b1000, 1'b1, 32'h7700_0000, 1, 32'h0);
    core_access(1'b1, 32'h0000_0408, 32'h7700_0000, 4'b1000, pcnt, din, r, ok);
    wait_bus_idle(pseen, ok);
    vectors++;
    if (!ok || bus_timeout !== 1'b1 || zZ_din !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL timeout_sticky_store: got ok=%b timeout=%b din=%h, want 1 1 0badf00d", ok, bus_timeout, zZ_din);
    end
  endtask

  task automatic test_reset_mid_read;
    push_txn(32'h0000_0500, 4'b1111, 1'b0, 32'h0, 0, 32'h0);
    Zz_addr = 32'h0000_0500;
    rd_en   = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midread_req: got bus_req=%b, want 1", bus_req);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus_req, zZ_din, bus_timeout} !== '0) begin
      miscompares++;
      $display("FAIL midread_reset: got req=%b din=%h timeout=%b, want 0 0 0", bus_req, zZ_din, bus_timeout);
    end
    rd_en = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1;
    vectors++;
    if ({pause, bus_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL midread_release: got pause=%b req=%b, want 0 0", pause, bus_req);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (bus_req !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL midread_no_retry: got req=%b pending=%0d, want 0 0", bus_req, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_posted_store;
    test_load_wait;
    test_back_to_back;
    test_boundary_ack;
    test_load_timeout;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Data-memory bus bridge directly downstream of the MEM stage. It consumes the stage's memory-side outputs: `Zz_addr`, `Zz_dout` and `Zz_wr_en`, plus a load strobe from decode. It drives a req/ack system bus and returns `zZ_din` to the MEM stage. Stores are posted through a single-entry write buffer. Loads are blocking and stall the pipeline via `pause` until the bus responds or a timeout fires.

## Interface
- `TIMEOUT`, default 255: maximum bus cycles with `bus_req` high before an access is aborted. The range is 1..65535.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `Zz_addr` in 32: byte address from the MEM stage.
- `Zz_dout` in 32: store data, already lane-replicated.
- `Zz_wr_en` in 4: byte-lane write enables. Bit3 is the byte at offset 0 (big-endian). A nonzero value means a store request.
- `rd_en` in 1: load request, valid in the same cycle as `Zz_addr`.
- `zZ_din` out 32: load data returned to the MEM stage.
- `pause` out 1: pipeline stall, combinational.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out 32: word-aligned address, `{Zz_addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables. Copy of `Zz_wr_en` for writes, 4'b1111 for reads.
- `bus_wdata` out 32: write data.
- `bus_ack` in 1: slave completion, one-cycle pulse.
- `bus_rdata` in 32: read data, valid when `bus_ack` = 1 on a read.
- `bus_timeout` out 1: sticky flag, set on any aborted access. Cleared only by `rst`.

## Operation
- **States:** IDLE, WR, RD, RDONE.
- **Request decode:**
  - `wr = |Zz_wr_en`
  - `rd = rd_en & ~wr`
  - If both `wr` and `rd_en` are asserted, the write wins and the load is ignored.
- **IDLE:**
  - On `wr`: capture address, data and lanes; go to WR. `pause` = 0, so the store is posted.
  - On `rd`: capture address; go to RD. `pause` = 1.
  - Otherwise stay in IDLE with `pause` = 0.
- **WR:**
  - `bus_req` = 1 and `bus_we` = 1.
  - `pause` = `wr | rd_en`: any new access stalls until the buffer drains.
  - On `bus_ack` or timeout, go to IDLE. The stalled access is then accepted by the IDLE rules.
- **RD:**
  - `bus_req` = 1, `bus_we` = 0, `pause` = 1.
  - On `bus_ack`, register `bus_rdata` into `zZ_din` and go to RDONE.
  - On timeout, set `zZ_din` = 0 and go to RDONE.
- **RDONE:**
  - `pause` = 0 and `bus_req` = 0. The held load retires in this cycle.
  - The request inputs are ignored; they still show the retiring load and must not be re-issued.
  - Next state is IDLE.
- **Register behaviour:**
  - `zZ_din` changes only on read completion. It holds otherwise, including across writes.
  - The bus address, data, `bus_be` and `bus_we` registers are loaded only on acceptance in IDLE. They are stable while `bus_req` = 1.
- **Timeout counter (16 bit):**
  - Cleared on acceptance; increments each cycle in WR/RD without ack.
  - When the count reaches `TIMEOUT-1` with no ack, the access aborts and `bus_timeout` is set.
  - `bus_req` is therefore high for at most `TIMEOUT` cycles.
  - An ack arriving on the final count cycle is a normal completion, with no timeout.
- **Core-side rule:** the core holds `Zz_*` and `rd_en` stable while `pause` = 1.
- **Reset:**
  - Asserting `rst` low at any time, including mid-access, forces IDLE.
  - All registered outputs (`zZ_din`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `bus_timeout`) go to 0, and the counter goes to 0.
  - `pause` reflects only the IDLE decode.
  - An in-flight bus transaction is dropped, not retried.

## Timing
- `bus_req` rises in the cycle after acceptance.
- `bus_req` falls in the cycle after `bus_ack` is sampled, or after the abort.
- **Posted store:** zero stall cycles when the bridge is in IDLE.
- **Load:** the stall is 1 cycle (the IDLE acceptance cycle) plus the number of RD cycles up to and including the ack. With an ack in the first RD cycle, `pause` is high for 2 cycles.
- `zZ_din` is valid from the RDONE cycle onward.
- **Back-to-back:** a load behind a posted store waits for the write ack, then takes the normal load path, so bus ordering is preserved.
- The slave must never assert `bus_ack` while `bus_req` = 0. Such an ack is ignored.

## Test plan
- **Reset mid-read:** drive `rst` = 0 in the second RD cycle. Required: `bus_req`, `zZ_din` and `bus_timeout` go to 0 immediately; after release, `pause` = 0 with no request present.
- **Posted store:** `Zz_addr` = 0x00001006, `Zz_wr_en` = 4'b0011, `Zz_dout` = 0xCCDDCCDD, ack on the 3rd request cycle. Required: `pause` never high; `bus_addr` = 0x00001004, `bus_be` = 4'b0011; `bus_req` high exactly 3 cycles.
- **Load with wait states:** `rd_en`, addr 0x00002000, ack with `bus_rdata` = 0x12345678 on the 3rd RD cycle. Required: `pause` high 4 cycles; `zZ_din` = 0x12345678 in RDONE with `pause` = 0; `bus_be` = 4'b1111.
- **Store then load at the same address 0x40:** write ack after 2 cycles. Required: the load stalls through WR; the read `bus_req` rises only after the write completes; returned data matches the slave.
- **Load timeout:** `TIMEOUT` = 4, no ack. Required: `bus_req` high exactly 4 cycles; `zZ_din` = 0; `bus_timeout` = 1 and stays 1 through later successful accesses.
- **Boundary ack:** `TIMEOUT` = 4, ack on the 4th request cycle with `bus_rdata` = 0xA5A5A5A5. Required: `zZ_din` = 0xA5A5A5A5 and `bus_timeout` stays 0.
